ibex_branch_predict_bht: RTL

//  Dynamic successor to the static fetch-stage predictor. Decodes the fetched instruction
//  (32-bit or compressed in [15:0]) for JAL/C.J/C.JAL and BRANCH/C.BEQZ/C.BNEZ. Computes the

---
 rtl/ibex_branch_predict_bht.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ibex_branch_predict_bht.sv
// Fetch-stage branch predictor: RV32IC jump/branch decode with a combinational target adder and a
// PC-indexed table of saturating direction counters, cleared by a sequential sweep on flush.
module ibex_branch_predict_bht #(
  parameter int unsigned BhtEntries = 64,
  parameter int unsigned CtrWidth   = 2,
  parameter bit          DynamicEn  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        flush_i,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(BhtEntries);

  localparam logic [6:0] OpcodeJal    = 7'h6f;
  localparam logic [6:0] OpcodeBranch = 7'h63;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  logic [31:0] instr;
  logic        is_j;
  logic        is_b;
  logic        is_cj;
  logic        is_cb;
  logic        is_jump;
  logic        is_cond;

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;
  logic [31:0] imm;
  logic        dir;

  assign instr = fetch_rdata_i;

  // Compressed forms live in quadrant 01; C.JAL (funct3 001) is the RV32-only encoding.
  assign is_j  = (instr[6:0] == OpcodeJal);
  assign is_b  = (instr[6:0] == OpcodeBranch);
  assign is_cj = (instr[1:0] == 2'b01) &&
                 ((instr[15:13] == 3'b101) || (instr[15:13] == 3'b001));
  assign is_cb = (instr[1:0] == 2'b01) && (instr[15:14] == 2'b11);

  assign is_jump = is_j | is_cj;
  assign is_cond = is_b | is_cb;

  assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_cj = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign imm_cb = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10],
                   instr[4:3], 1'b0};

  always_comb begin
    imm = imm_b;
    if (is_j) begin
      imm = imm_j;
    end else if (is_cj) begin
      imm = imm_cj;
    end else if (is_cb) begin
      imm = imm_cb;
    end
  end

  assign predict_branch_pc_o    = fetch_pc_i + imm;
  assign predict_branch_taken_o = fetch_valid_i & (is_jump | (is_cond & dir));

  if (DynamicEn) begin : g_dyn
    localparam int CtrRstInt = (1 << (CtrWidth - 1)) - 1;
    localparam logic [CtrWidth-1:0] CtrRst  = CtrRstInt[CtrWidth-1:0];
    localparam logic [CtrWidth-1:0] CtrMax  = '1;
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(BhtEntries - 1);

    state_e              state;
    state_e              state_next;
    logic [IdxW-1:0]     clr_ptr;
    logic [IdxW-1:0]     clr_ptr_next;
    logic [CtrWidth-1:0] ctr [BhtEntries];
    logic [BhtEntries-1:0] ctr_msb;

    logic [IdxW-1:0]     lookup_idx;
    logic [IdxW-1:0]     update_idx;
    logic [CtrWidth-1:0] upd_cur;
    logic [CtrWidth-1:0] upd_new;
    logic                upd_we;
    logic                unused_update_pc;

    assign lookup_idx = fetch_pc_i[IdxW:1];
    assign update_idx = update_pc_i[IdxW:1];
    assign unused_update_pc = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};

    for (genvar gi = 0; gi < BhtEntries; gi++) begin : g_msb
      assign ctr_msb[gi] = ctr[gi][CtrWidth-1];
    end

    assign upd_cur = ctr[update_idx];

    always_comb begin
      upd_new = upd_cur;
      if (update_taken_i) begin
        if (upd_cur != CtrMax) begin
          upd_new = upd_cur + 1'b1;
        end
      end else if (upd_cur != '0) begin
        upd_new = upd_cur - 1'b1;
      end
    end

    // A flush in the same cycle as a resolution wins; resolutions during a sweep are lost.
    assign upd_we = update_valid_i & ~flush_i & (state == IDLE);

    always_comb begin
      state_next   = state;
      clr_ptr_next = clr_ptr;
      case (state)
        IDLE: begin
          if (flush_i) begin
            state_next   = CLEAR;
            clr_ptr_next = '0;
          end
        end
        CLEAR: begin
          if (flush_i) begin
            clr_ptr_next = '0;
          end else if (clr_ptr == LastIdx) begin
            state_next   = IDLE;
            clr_ptr_next = '0;
          end else begin
            clr_ptr_next = clr_ptr + 1'b1;
          end
        end
        default: begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= IDLE;
        clr_ptr <= '0;
      end else begin
        state   <= state_next;
        clr_ptr <= clr_ptr_next;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < BhtEntries; i++) begin
          ctr[i] <= CtrRst;
        end
      end else if (state == CLEAR) begin
        ctr[clr_ptr] <= CtrRst;
      end else if (upd_we) begin
        ctr[update_idx] <= upd_new;
      end
    end

    // Half-cleared table contents are never trusted: fall back to static while sweeping.
    assign dir    = (state == IDLE) ? ctr_msb[lookup_idx] : imm[31];
    assign busy_o = (state == CLEAR);
  end else begin : g_static
    logic unused_static_inputs;

    assign unused_static_inputs = ^{clk_i, rst_i, update_valid_i, update_pc_i,
                                    update_taken_i, flush_i};
    assign dir    = imm[31];
    assign busy_o = 1'b0;
  end

endmodule
